// File: rtl/seq_datapath_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_datapath_core
// Function : Multi-cycle Mini SRC core with a register file, HI/LO, ALU,
//            shift-add signed multiplier and a req/ack memory port.
// Revision : 1.0
// ============================================================================
module seq_datapath_core #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int RW    = $clog2(NREGS);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MUL    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [31:0]         ir;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   opd;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]    cnt;
    logic                neg;

    logic [4:0]          opcode;
    logic [RW-1:0]       ra;
    logic [RW-1:0]       rb;
    logic [RW-1:0]       rc;
    logic [DATA_W-1:0]   cimm;
    logic                uses_base;
    logic                uses_imm;
    logic                writes_ra;
    logic                simple_end;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   ea;
    logic [DATA_W:0]     step_sum;
    logic [2*DATA_W-1:0] prod_next;
    logic [2*DATA_W-1:0] prod_final;
    logic                xfer_done;
    logic                instr_end;
    logic                unused_sink;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    assign opcode = ir[31:27];
    assign ra     = ir[23 +: RW];
    assign rb     = ir[19 +: RW];
    assign rc     = ir[15 +: RW];
    assign cimm   = {{(DATA_W-19){ir[18]}}, ir[18:0]};

    assign uses_base = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
    assign uses_imm  = uses_base || (opcode == OP_ADDI) || (opcode == OP_ANDI)
                     || (opcode == OP_ORI);

    always_comb begin
        alu_res   = '0;
        writes_ra = 1'b1;
        case (opcode)
            OP_LDI, OP_ADD, OP_ADDI: alu_res = opa + opb;
            OP_SUB:                  alu_res = opa - opb;
            OP_SHR:                  alu_res = opa >> opb[SH_W-1:0];
            OP_SHL:                  alu_res = opa << opb[SH_W-1:0];
            OP_AND, OP_ANDI:         alu_res = opa & opb;
            OP_OR, OP_ORI:           alu_res = opa | opb;
            OP_MFHI:                 alu_res = hi;
            OP_MFLO:                 alu_res = lo;
            default:                 writes_ra = 1'b0;
        endcase
    end

    assign simple_end = writes_ra || (opcode == OP_NOP);
    assign ea         = opa + opb;

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole product/multiplier pair right by one.
    assign step_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]}
                      + (prod[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
    assign prod_next  = {step_sum, prod[DATA_W-1:1]};
    assign prod_final = neg ? -prod_next : prod_next;

    assign xfer_done = mem_req && mem_ack;
    assign instr_end = ((state == S_EXEC) && simple_end)
                     || ((state == S_MEM) && xfer_done)
                     || ((state == S_MUL) && (cnt == CNT_W'(1)));

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state     <= S_IDLE;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            hi        <= '0;
            lo        <= '0;
            opa       <= '0;
            opb       <= '0;
            opd       <= '0;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            illegal   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (xfer_done) begin
                        ir      <= mem_rdata[31:0];
                        pc      <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= (uses_base && (rb == '0)) ? '0 : regs[rb];
                    opb   <= uses_imm ? cimm : regs[rc];
                    opd   <= regs[ra];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (writes_ra) begin
                        regs[ra] <= alu_res;
                    end
                    if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                        mem_req  <= 1'b1;
                        mem_we   <= (opcode == OP_ST);
                        mem_addr <= ea[ADDR_W-1:0];
                        if (opcode == OP_ST) begin
                            mem_wdata <= opd;
                        end
                        state <= S_MEM;
                    end else if (opcode == OP_MUL) begin
                        mcand <= mag(opd);
                        prod  <= {{DATA_W{1'b0}}, mag(opa)};
                        neg   <= opd[DATA_W-1] ^ opa[DATA_W-1];
                        cnt   <= CNT_W'(DATA_W);
                        state <= S_MUL;
                    end else if (opcode == OP_HALT) begin
                        state <= S_HALT;
                    end else if (!simple_end) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_MEM: begin
                    if (xfer_done) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (opcode == OP_LD) begin
                            regs[ra] <= mem_rdata;
                        end
                    end
                end
                S_MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= prod_final;
                    end
                end
                default: ;
            endcase

            // The END decision is folded into the last edge of each instruction.
            if (instr_end) begin
                if (run) begin
                    state    <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

    assign dbg_data = regs[dbg_sel[RW-1:0]];
    assign pc_out   = pc;
    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign halted   = (state == S_HALT);

    // Field bits not used by every NREGS/DATA_W combination.
    assign unused_sink = ^{ir, ea, dbg_sel, mem_rdata};

endmodule
`default_nettype wire
